pes_vm_dispenser: RTL and testbench
===================================

PES_VM_DISPENSER -- requirements
Module: pes_vm_dispenser

Interface
REQ-001 Parameter MOTOR_CYCLES, default 4, sets the length of the product-motor pulse in clock cycles.
REQ-002 Parameter COIN_CYCLES, default 2, sets the length of each coin-ejector pulse in clock cycles.
REQ-003 Parameter GAP_CYCLES, default 2, sets the idle gap after every motor or coin pulse.
REQ-004 Parameter DEPTH, default 4, sets the number of entries in the event queue.
REQ-005 clock  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 out  in  1  vend event from pes_vm; 1 = dispense one product this cycle.
REQ-008 change  in  2  change event from pes_vm; value = number of 5-unit coins to return (0..3).
REQ-009 motor_pulse  out  1  product-motor drive, registered.
REQ-010 coin_pulse  out  1  coin-ejector drive, registered; one pulse per 5-unit coin.
REQ-011 busy  out  1  high while the queue is non-empty or the FSM is not in IDLE.
REQ-012 pending  out  3  current queue occupancy, 0..DEPTH.
REQ-013 overflow  out  1  sticky flag; set when an event is dropped.

Function
REQ-014 An event SHALL be defined as any cycle with out=1 or change!=0; that cycle's {out,change} SHALL be pushed at the same edge.
REQ-015 The queue SHALL be FIFO-ordered; an event arriving while the queue is full and no pop occurs SHALL be dropped and SHALL set overflow.
REQ-016 A push and a pop at the same edge SHALL both take effect, leaving pending unchanged, including when the queue is full.
REQ-017 FSM states SHALL be IDLE, MOTOR_ON, MOTOR_GAP, COIN_ON and COIN_GAP.
REQ-018 In IDLE with pending>0, the FSM SHALL pop the head entry and latch its vend bit and coin count.
- next state is MOTOR_ON if the vend bit is 1, else COIN_ON.
REQ-019 MOTOR_ON SHALL last MOTOR_CYCLES cycles, then go to MOTOR_GAP.
REQ-020 MOTOR_GAP SHALL last GAP_CYCLES cycles, then go to COIN_ON if the coin count is >0, else IDLE.
REQ-021 COIN_ON SHALL last COIN_CYCLES cycles and decrement the coin count on exit, then go to COIN_GAP.
REQ-022 COIN_GAP SHALL last GAP_CYCLES cycles, then go to COIN_ON if the coin count is >0, else IDLE.
REQ-023 motor_pulse SHALL be high exactly in MOTOR_ON; coin_pulse SHALL be high exactly in COIN_ON; the two SHALL never be high together.
REQ-024 Latency: for an event presented in cycle N to an idle, empty block, the first pulse SHALL go high in cycle N+2.
REQ-025 Timer and coin counters SHALL be width-sized so that they do not wrap for any parameter value of 1..255.
REQ-026 overflow SHALL clear only on reset.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE and the queue SHALL empty.
REQ-028 motor_pulse, coin_pulse, busy, overflow and pending SHALL all be 0 in the cycle after reset is sampled high, including when reset is asserted mid-pulse.
REQ-029 Events presented while reset is high SHALL be ignored.

Structure
REQ-030 Shared package pes_vm_pkg SHALL hold:
- the FSM state enum;
- the change-encoding constants (CHG_NONE=0, CHG_5=1, CHG_10=2, CHG_15=3);
- the default values of MOTOR_CYCLES, COIN_CYCLES, GAP_CYCLES and DEPTH.
REQ-031 The event queue SHALL be a separate sub-module, pes_vm_evq: synchronous FIFO with push, pop, full, empty and count.

Verification
REQ-032 Reset held for 2 cycles, then released with no stimulus -> all outputs stay 0 for 20 cycles.
REQ-033 out=1, change=0 for one cycle (N) -> motor_pulse high in cycles N+2..N+5, coin_pulse never high, busy low from N+8.
REQ-034 out=1, change=2 (cycle N):
- motor_pulse high in N+2..N+5;
- coin_pulse high in N+8..N+9 and N+12..N+13;
- busy low from N+16.
REQ-035 out=0, change=3 (cycle N) -> three coin_pulse pulses of 2 cycles each, starting at N+2, N+6 and N+10; motor_pulse stays 0.
REQ-036 Six consecutive events of out=1 -> pending reaches 4, overflow set at the sixth event, exactly 5 motor pulses produced, overflow still 1 afterwards.
REQ-037 Reset asserted during the second cycle of MOTOR_ON with pending=2 -> next cycle motor_pulse=0, pending=0, busy=0, overflow=0, and no further pulses.

Source files
------------

// File: rtl/pes_vm_pkg.sv
// Shared types and constants for the vending-machine dispenser: FSM states,
// change encoding, queued event layout and default pulse timing.
package pes_vm_pkg;

    localparam int MOTOR_CYCLES_DEF = 4;
    localparam int COIN_CYCLES_DEF  = 2;
    localparam int GAP_CYCLES_DEF   = 2;
    localparam int DEPTH_DEF        = 4;

    localparam logic [1:0] CHG_NONE = 2'd0;
    localparam logic [1:0] CHG_5    = 2'd1;
    localparam logic [1:0] CHG_10   = 2'd2;
    localparam logic [1:0] CHG_15   = 2'd3;

    // Wide enough to hold a reload value of 254 (parameter 255 minus one).
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        MOTOR_ON,
        MOTOR_GAP,
        COIN_ON,
        COIN_GAP
    } state_t;

    typedef struct packed {
        logic       vend;
        logic [1:0] coins;
    } evt_t;

endpackage

// File: rtl/pes_vm_dispenser_if.sv
// Event and actuator signals between the vending controller (master) and
// the dispenser (slave).
interface pes_vm_dispenser_if;
    logic       out;
    logic [1:0] change;
    logic       motor_pulse;
    logic       coin_pulse;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    modport master (
        output out, change,
        input  motor_pulse, coin_pulse, busy, pending, overflow
    );

    modport slave (
        input  out, change,
        output motor_pulse, coin_pulse, busy, pending, overflow
    );
endinterface

// File: rtl/pes_vm_evq.sv
// Synchronous event FIFO; a push while full is accepted only when a pop
// frees a slot at the same edge.
module pes_vm_evq
    import pes_vm_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  evt_t          wdata,
    output evt_t          rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is carried
    // by the pointers and count, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pes_vm_dispenser.sv
// Vend/change event dispenser: queues events and replays each one as a
// motor pulse followed by one coin pulse per 5-unit coin, with idle gaps.
module pes_vm_dispenser
    import pes_vm_pkg::*;
#(
    parameter int MOTOR_CYCLES = MOTOR_CYCLES_DEF,
    parameter int COIN_CYCLES  = COIN_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    pes_vm_dispenser_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [TIMER_W-1:0] T_MOTOR = TIMER_W'(MOTOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_COIN  = TIMER_W'(COIN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_GAP   = TIMER_W'(GAP_CYCLES - 1);

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [1:0]         coins, coins_next;
    logic               pop;
    logic               evt_valid;
    evt_t               head;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic               motor_q;
    logic               coin_q;
    logic               overflow_q;

    assign evt_valid = (bus.out || (bus.change != CHG_NONE)) && !reset;

    pes_vm_evq #(.DEPTH(DEPTH)) u_evq (
        .clock (clock),
        .reset (reset),
        .push  (evt_valid),
        .pop   (pop),
        .wdata ('{vend: bus.out, coins: bus.change}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            coins      <= '0;
            motor_q    <= 1'b0;
            coin_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            coins   <= coins_next;
            motor_q <= (state_next == MOTOR_ON);
            coin_q  <= (state_next == COIN_ON);
            if (evt_valid && full && !pop) overflow_q <= 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        timer_next = timer;
        coins_next = coins;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    coins_next = head.coins;
                    if (head.vend) begin
                        state_next = MOTOR_ON;
                        timer_next = T_MOTOR;
                    end else if (head.coins != CHG_NONE) begin
                        state_next = COIN_ON;
                        timer_next = T_COIN;
                    end
                end
            end
            MOTOR_ON: begin
                if (timer == '0) begin
                    state_next = MOTOR_GAP;
                    timer_next = T_GAP;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            COIN_ON: begin
                if (timer == '0) begin
                    state_next = COIN_GAP;
                    timer_next = T_GAP;
                    coins_next = coins - 1'b1;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            MOTOR_GAP, COIN_GAP: begin
                if (timer != '0) begin
                    timer_next = timer - 1'b1;
                end else if (coins != '0) begin
                    state_next = COIN_ON;
                    timer_next = T_COIN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.motor_pulse = motor_q;
    assign bus.coin_pulse  = coin_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = !empty || (state != IDLE);
    assign bus.pending     = 3'(count);

endmodule

// File: tb/tb_pes_vm_dispenser.sv
// Directed bench for pes_vm_dispenser: per-cycle output masks compared with
// hand-derived expectations for each event pattern, overflow and reset cases.
module tb_pes_vm_dispenser;
    import pes_vm_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pes_vm_dispenser_if dif ();

    pes_vm_dispenser dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        dif.out    = 1'b0;
        dif.change = CHG_NONE;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Presents one event in cycle N and records outputs for N..N+23.
    task automatic run_event(input string tag, input logic vend, input logic [1:0] chg,
                             input logic [31:0] exp_motor, input logic [31:0] exp_coin,
                             input logic [31:0] exp_busy);
        logic [31:0] m, c, b;
        m = '0; c = '0; b = '0;
        dif.out    = vend;
        dif.change = chg;
        for (int k = 0; k < 24; k++) begin
            if (k == 1) begin
                dif.out    = 1'b0;
                dif.change = CHG_NONE;
            end
            m[k] = dif.motor_pulse;
            c[k] = dif.coin_pulse;
            b[k] = dif.busy;
            next_cycle();
        end
        check({tag, "_motor"}, m, exp_motor);
        check({tag, "_coin"}, c, exp_coin);
        check({tag, "_busy"}, b, exp_busy);
        check({tag, "_excl"}, m & c, 32'h0);
    endtask

    initial begin
        logic [31:0] m_or, c_or, b_or, p_or, o_or;
        logic [2:0]  pend_max;
        logic        prev;
        int          pulses;

        dif.out    = 1'b0;
        dif.change = CHG_NONE;

        // Reset for two cycles, then idle with no stimulus.
        next_cycle();
        next_cycle();
        check("rst_motor",    32'(dif.motor_pulse), 32'h0);
        check("rst_coin",     32'(dif.coin_pulse),  32'h0);
        check("rst_busy",     32'(dif.busy),        32'h0);
        check("rst_pending",  32'(dif.pending),     32'h0);
        check("rst_overflow", 32'(dif.overflow),    32'h0);
        reset = 1'b0;
        m_or = '0; c_or = '0; b_or = '0; p_or = '0; o_or = '0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            m_or |= 32'(dif.motor_pulse);
            c_or |= 32'(dif.coin_pulse);
            b_or |= 32'(dif.busy);
            p_or |= 32'(dif.pending);
            o_or |= 32'(dif.overflow);
        end
        check("idle_motor",    m_or, 32'h0);
        check("idle_coin",     c_or, 32'h0);
        check("idle_busy",     b_or, 32'h0);
        check("idle_pending",  p_or, 32'h0);
        check("idle_overflow", o_or, 32'h0);

        // Vend only: motor N+2..N+5, busy N+1..N+7.
        run_event("vend", 1'b1, CHG_NONE, 32'h0000_003C, 32'h0000_0000, 32'h0000_00FE);
        // Vend plus 10 change: coins N+8..9 and N+12..13, busy N+1..N+15.
        run_event("vend_c10", 1'b1, CHG_10, 32'h0000_003C, 32'h0000_3300, 32'h0000_FFFE);
        // Change only, 15: coins at N+2, N+6, N+10, busy N+1..N+13.
        run_event("c15", 1'b0, CHG_15, 32'h0000_0000, 32'h0000_0CCC, 32'h0000_3FFE);
        // Change only, 5: single coin pulse N+2..N+3, busy N+1..N+5.
        run_event("c5", 1'b0, CHG_5, 32'h0000_0000, 32'h0000_000C, 32'h0000_003E);

        // Six back-to-back vends: queue fills to 4, sixth is dropped.
        check("ovf_pre", 32'(dif.overflow), 32'h0);
        pend_max = '0; prev = 1'b0; pulses = 0;
        for (int k = 0; k < 60; k++) begin
            dif.out = (k < 6);
            if (dif.pending > pend_max) pend_max = dif.pending;
            if (dif.motor_pulse && !prev) pulses++;
            prev = dif.motor_pulse;
            if (k == 5) begin
                check("six_pending_full", 32'(dif.pending),  32'd4);
                check("six_ovf_before",   32'(dif.overflow), 32'h0);
            end
            if (k == 6) check("six_ovf_set", 32'(dif.overflow), 32'h1);
            next_cycle();
        end
        dif.out = 1'b0;
        check("six_pending_max", 32'(pend_max), 32'd4);
        check("six_pulses",      32'(pulses),   32'd5);
        check("six_ovf_sticky",  32'(dif.overflow), 32'h1);
        check("six_busy_done",   32'(dif.busy), 32'h0);

        // Reset in the second MOTOR_ON cycle with two events queued.
        for (int k = 0; k < 3; k++) begin
            dif.out = 1'b1;
            next_cycle();
        end
        dif.out = 1'b0;
        check("mid_pre_motor",   32'(dif.motor_pulse), 32'h1);
        check("mid_pre_pending", 32'(dif.pending),     32'd2);
        check("mid_pre_ovf",     32'(dif.overflow),    32'h1);
        reset = 1'b1;
        next_cycle();
        check("mid_motor",    32'(dif.motor_pulse), 32'h0);
        check("mid_coin",     32'(dif.coin_pulse),  32'h0);
        check("mid_pending",  32'(dif.pending),     32'h0);
        check("mid_busy",     32'(dif.busy),        32'h0);
        check("mid_overflow", 32'(dif.overflow),    32'h0);
        reset = 1'b0;
        m_or = '0; c_or = '0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            m_or |= 32'(dif.motor_pulse);
            c_or |= 32'(dif.coin_pulse);
        end
        check("mid_after_motor", m_or, 32'h0);
        check("mid_after_coin",  c_or, 32'h0);

        // Push and pop at the same edge while full: pending holds at 4.
        apply_reset();
        prev = 1'b0; pulses = 0;
        for (int k = 0; k < 70; k++) begin
            dif.out = (k < 9);
            if (dif.motor_pulse && !prev) pulses++;
            prev = dif.motor_pulse;
            if (k == 4)  check("pp_pending_n4",  32'(dif.pending), 32'd3);
            if (k == 8)  check("pp_pending_n8",  32'(dif.pending), 32'd4);
            if (k == 9)  check("pp_pending_n9",  32'(dif.pending), 32'd4);
            if (k == 10) check("pp_pending_n10", 32'(dif.pending), 32'd4);
            next_cycle();
        end
        dif.out = 1'b0;
        check("pp_pulses", 32'(pulses), 32'd6);
        check("pp_ovf",    32'(dif.overflow), 32'h1);

        // Events presented while reset is high are ignored.
        reset      = 1'b1;
        dif.out    = 1'b1;
        dif.change = CHG_15;
        next_cycle();
        next_cycle();
        next_cycle();
        reset      = 1'b0;
        dif.out    = 1'b0;
        dif.change = CHG_NONE;
        m_or = '0; c_or = '0; b_or = '0; p_or = '0;
        for (int k = 0; k < 12; k++) begin
            m_or |= 32'(dif.motor_pulse);
            c_or |= 32'(dif.coin_pulse);
            b_or |= 32'(dif.busy);
            p_or |= 32'(dif.pending);
            next_cycle();
        end
        check("rstev_motor",   m_or, 32'h0);
        check("rstev_coin",    c_or, 32'h0);
        check("rstev_busy",    b_or, 32'h0);
        check("rstev_pending", p_or, 32'h0);
        check("rstev_ovf",     32'(dif.overflow), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
